inst_mem_loader: RTL

Parametrised instruction-memory loader between the UART receiver and the processor fetch port. Accepts a stream of bytes from the UART RX byte strobe, assembles them little-endian into DATA_W-bit instruction words and writes them sequentially into an on-chip memory. Gives the core a registered read port, and gives the board load status plus an 8-bit LED debug view of one selected word. Fully synchronous byte capture on clk; no edge-triggering on data strobes.

---
 rtl/inst_mem_loader_if.sv | 37 +++
 rtl/inst_mem_loader.sv | 129 ++++++++++++
 2 files changed

// File: rtl/inst_mem_loader_if.sv
// Bus bundle between the UART byte receiver, the fetch port and the board status of inst_mem_loader.
// The checksum signal exists only when IMEM_CHECKSUM_EN is defined.
interface inst_mem_loader_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              load_start;
  logic              load_stop;
  logic              busy;
  logic              load_done;
  logic              overflow;
  logic [ADDR_W:0]   word_count;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic [7:0]        LED;
`ifdef IMEM_CHECKSUM_EN
  logic [7:0]        checksum;
`endif

  modport master (
    output rx_data, rx_valid, load_start, load_stop, rd_addr,
    input  busy, load_done, overflow, word_count, rd_data, LED
`ifdef IMEM_CHECKSUM_EN
    , input checksum
`endif
  );

  modport slave (
    input  rx_data, rx_valid, load_start, load_stop, rd_addr,
    output busy, load_done, overflow, word_count, rd_data, LED
`ifdef IMEM_CHECKSUM_EN
    , output checksum
`endif
  );
endinterface

// File: rtl/inst_mem_loader.sv
// Loads UART bytes little-endian into an instruction memory with a registered fetch port.
// Define IMEM_CHECKSUM_EN to add an 8-bit running sum of the bytes accepted during a load.
module inst_mem_loader #(
  parameter int         DATA_W    = 32,
  parameter int         DEPTH     = 256,
  parameter int         ADDR_W    = $clog2(DEPTH),
  parameter int         LED_ADDR  = 4,
  parameter logic [7:0] INIT_BYTE = 8'h55
) (
  input logic              clk,
  input logic              rst,
  inst_mem_loader_if.slave bus
);
  localparam int BYTES  = DATA_W / 8;
  localparam int BCNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W:0]     wc_q, wc_d, wc_inc;
  logic [BCNT_W-1:0]   bc_q, bc_d;
  logic [DATA_W-1:0]   asm_q, asm_d, merged;
  logic                ovf_q, ovf_d;
  logic                we;
  logic [ADDR_W-1:0]   waddr;
  logic [DATA_W-1:0]   rd_q;
  logic [7:0]          led_q;
`ifdef IMEM_CHECKSUM_EN
  logic [7:0]          csum_q, csum_d;
`endif

  // Power-up contents come from the FPGA bitstream; rst never touches them.
  logic [DATA_W-1:0] mem_q [DEPTH] = '{default: {BYTES{INIT_BYTE}}};

  assign wc_inc = wc_q + (ADDR_W + 1)'(1);
  assign waddr  = wc_q[ADDR_W-1:0];

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    wc_d    = wc_q;
    bc_d    = bc_q;
    asm_d   = asm_q;
    ovf_d   = ovf_q;
    we      = 1'b0;
    merged  = asm_q;
    merged[8*int'(bc_q) +: 8] = bus.rx_data;
`ifdef IMEM_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    if (bus.load_start) begin
      state_d = LOAD;
      wc_d    = '0;
      bc_d    = '0;
      asm_d   = '0;
      ovf_d   = 1'b0;
`ifdef IMEM_CHECKSUM_EN
      csum_d  = '0;
`endif
    end else begin
      unique case (state_q)
        LOAD: begin
          if (bus.load_stop) begin
            state_d = DONE;
            bc_d    = '0;
            asm_d   = '0;
          end else if (bus.rx_valid) begin
            asm_d = merged;
`ifdef IMEM_CHECKSUM_EN
            csum_d = csum_q + bus.rx_data;
`endif
            if (bc_q == BCNT_W'(BYTES - 1)) begin
              we   = 1'b1;
              wc_d = wc_inc;
              bc_d = '0;
              if (wc_inc == (ADDR_W + 1)'(DEPTH)) state_d = DONE;
            end else begin
              bc_d = bc_q + BCNT_W'(1);
            end
          end
        end
        DONE:    if (bus.rx_valid) ovf_d = 1'b1;
        default: ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      wc_q    <= '0;
      bc_q    <= '0;
      asm_q   <= '0;
      ovf_q   <= 1'b0;
      rd_q    <= '0;
      led_q   <= INIT_BYTE;
`ifdef IMEM_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      wc_q    <= wc_d;
      bc_q    <= bc_d;
      asm_q   <= asm_d;
      ovf_q   <= ovf_d;
      rd_q    <= mem_q[bus.rd_addr];
      if (we && waddr == ADDR_W'(LED_ADDR)) led_q <= merged[7:0];
`ifdef IMEM_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  // NOTE: the memory array has no reset branch so it maps onto block RAM and survives rst.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= merged;
  end

  assign bus.busy       = (state_q == LOAD);
  assign bus.load_done  = (state_q == DONE);
  assign bus.overflow   = ovf_q;
  assign bus.word_count = wc_q;
  assign bus.rd_data    = rd_q;
  assign bus.LED        = led_q;
`ifdef IMEM_CHECKSUM_EN
  assign bus.checksum   = csum_q;
`endif
endmodule
